log_merge_scheduler: RTL and testbench

LOG_MERGE_SCHEDULER -- requirements
Module: log_merge_scheduler

---
 rtl/log_merge_pkg.sv | 18 +
 rtl/log_merge_scheduler_lsb_index_find.sv | 24 ++
 rtl/log_merge_scheduler.sv | 171 +++++++++++++++++
 tb/tb_log_merge_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_merge_pkg.sv
// Shared types and header field layout for the log merge scheduler.
// Header word: {zero pad, delta, bitmap} with the bitmap in the low bits.
package log_merge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam int BITMAP_LSB = 0;

   // The delta field sits directly above the NCH-bit bitmap.
   function automatic int delta_lsb(input int nch);
      return nch;
   endfunction

endpackage

// File: rtl/log_merge_scheduler_lsb_index_find.sv
// Lowest-set-bit finder: returns the index of the lowest set bit of mask
// and whether any bit was set at all.
module lsb_index_find
   import log_merge_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] mask,
   output logic [IW-1:0]  index,
   output logic           found
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         index = mask[i] ? IW'(i) : index;
         found = found | mask[i];
      end
   end

endmodule

// File: rtl/log_merge_scheduler.sv
// Merges NCH logging channels into one packetised stream: a header beat
// carrying the time delta and channel bitmap, followed by each captured payload.
module log_merge_scheduler
   import log_merge_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TS_WIDTH   = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NCH-1:0]            in_valid,
   output logic [NCH-1:0]            in_ready,
   input  logic [NCH*DATA_WIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_last
);

   localparam int IW        = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DELTA_LSB = delta_lsb(NCH);

   state_t                state_r;
   logic [TS_WIDTH-1:0]   cnt_r;
   logic [NCH-1:0]        bitmap_r;
   logic [IW-1:0]         idx_r;
   logic [DATA_WIDTH-1:0] payload_r [NCH];
   logic                  out_valid_r;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  out_last_r;

   logic                  cnt_sat_s;
   logic                  capture_s;
   logic [DATA_WIDTH-1:0] hdr_word_s;
   logic [NCH-1:0]        next_mask_s;
   logic [NCH-1:0]        last_mask_s;
   logic [IW-1:0]         first_idx_s;
   logic                  first_found_s;
   logic [IW-1:0]         next_idx_s;
   logic                  next_found_s;
   logic [IW-1:0]         new_idx_s;
   logic                  new_last_s;

   lsb_index_find #(.NCH(NCH), .IW(IW)) u_first_find (
      .mask  (bitmap_r),
      .index (first_idx_s),
      .found (first_found_s)
   );

   lsb_index_find #(.NCH(NCH), .IW(IW)) u_next_find (
      .mask  (next_mask_s),
      .index (next_idx_s),
      .found (next_found_s)
   );

   // Capture decision and header word assembled from the live inputs.
   always_comb begin
      cnt_sat_s  = &cnt_r;
      capture_s  = 1'b0;
      hdr_word_s = '0;
      hdr_word_s[DELTA_LSB +: TS_WIDTH] = cnt_r;
      hdr_word_s[BITMAP_LSB +: NCH]     = in_valid;
      if (state_r == IDLE) begin
         capture_s = (|in_valid) | cnt_sat_s;
      end else begin
         capture_s = 1'b0;
      end
   end

   // Index bookkeeping: the beat about to be presented and whether it ends the packet.
   always_comb begin
      next_mask_s = '0;
      last_mask_s = '0;
      if (state_r == HDR) begin
         new_idx_s = first_idx_s;
      end else begin
         new_idx_s = next_idx_s;
      end
      for (int i = 0; i < NCH; i++) begin
         next_mask_s[i] = bitmap_r[i] && (IW'(i) > idx_r);
         last_mask_s[i] = bitmap_r[i] && (IW'(i) > new_idx_s);
      end
      new_last_s = ~|last_mask_s;
   end

   // Channels are accepted only while idle, and never while reset is held.
   always_comb begin
      if (rstn && (state_r == IDLE)) begin
         in_ready = in_valid;
      end else begin
         in_ready = '0;
      end
   end

   // Payload capture; holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (capture_s && in_valid[i]) begin
            payload_r[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Control FSM, delta counter and registered output beat.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         bitmap_r    <= '0;
         idx_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
      end else begin
         if (capture_s) begin
            cnt_r <= TS_WIDTH'(1);
         end else if (!cnt_sat_s) begin
            cnt_r <= cnt_r + TS_WIDTH'(1);
         end
         case (state_r)
            IDLE: begin
               if (capture_s) begin
                  state_r     <= HDR;
                  bitmap_r    <= in_valid;
                  out_valid_r <= 1'b1;
                  out_data_r  <= hdr_word_s;
                  out_last_r  <= ~|in_valid;
               end
            end
            HDR: begin
               if (out_ready) begin
                  if (!first_found_s) begin
                     state_r     <= IDLE;
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     state_r    <= DATA;
                     idx_r      <= new_idx_s;
                     out_data_r <= payload_r[new_idx_s];
                     out_last_r <= new_last_s;
                  end
               end
            end
            DATA: begin
               if (out_ready) begin
                  if (!next_found_s) begin
                     state_r     <= IDLE;
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     idx_r      <= new_idx_s;
                     out_data_r <= payload_r[new_idx_s];
                     out_last_r <= new_last_s;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;

endmodule

// File: tb/tb_log_merge_scheduler.sv
// Directed and randomized stream checks for log_merge_scheduler
// (NCH=4, DATA_WIDTH=32, TS_WIDTH=4).
module tb_log_merge_scheduler;

   logic         clk;
   logic         rstn;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic         out_last;

   int checks;
   int errors;
   int cyc;
   logic [31:0] q [4][$];

   log_merge_scheduler #(.NCH(4), .DATA_WIDTH(32), .TS_WIDTH(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rstn = 1'b0; in_valid = 4'b1111; in_data = '0; out_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset: out_valid=%b out_last=%b in_ready=%b want 0 0 0000", out_valid, out_last, in_ready);
      end
      in_valid = 4'b0000;
      rstn = 1'b1;
      cyc = 0;
   endtask

   task automatic test_single();
      repeat (10) step();
      in_valid = 4'b0100; in_data = {32'd0, 32'h000000A5, 64'd0};
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++; $display("FAIL single_ready: got %b want 0100", in_ready);
      end
      step();
      in_valid = 4'b0000;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h000000A4 || out_last !== 1'b0) begin
         errors++; $display("FAIL single_hdr: v=%b d=%h l=%b want 1 000000a4 0", out_valid, out_data, out_last);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h000000A5 || out_last !== 1'b1) begin
         errors++; $display("FAIL single_beat: v=%b d=%h l=%b want 1 000000a5 1", out_valid, out_data, out_last);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL single_end: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] exp_beats [3];
      logic        exp_last [3];
      exp_beats[0] = 32'h11; exp_beats[1] = 32'h22; exp_beats[2] = 32'h33;
      exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b1;
      in_valid = 4'b1011; in_data = {32'h33, 32'h99, 32'h22, 32'h11};
      #1;
      checks++;
      if (in_ready !== 4'b1011) begin
         errors++; $display("FAIL simul_ready: got %b want 1011", in_ready);
      end
      step();
      in_valid = 4'b0000;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000003B || out_last !== 1'b0) begin
         errors++; $display("FAIL simul_hdr: v=%b d=%h l=%b want 1 0000003b 0", out_valid, out_data, out_last);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_beats[i] || out_last !== exp_last[i]) begin
            errors++; $display("FAIL simul_beat%0d: d=%h l=%b want %h %b", i, out_data, out_last, exp_beats[i], exp_last[i]);
         end
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL simul_end: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      in_valid = 4'b0111; in_data = {32'h0, 32'h66, 32'h55, 32'h44};
      step();
      in_valid = 4'b0000;
      checks++;
      if (out_data !== 32'h00000057 || out_last !== 1'b0) begin
         errors++; $display("FAIL bp_hdr: d=%h l=%b want 00000057 0", out_data, out_last);
      end
      step();
      checks++;
      if (out_data !== 32'h44 || out_last !== 1'b0) begin
         errors++; $display("FAIL bp_beat0: d=%h l=%b want 00000044 0", out_data, out_last);
      end
      out_ready = 1'b0; in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'h44 || out_last !== 1'b0 || in_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_stall%0d: v=%b d=%h l=%b rdy=%b want 1 00000044 0 0000", i, out_valid, out_data, out_last, in_ready);
         end
      end
      out_ready = 1'b1; in_valid = 4'b0000;
      step();
      checks++;
      if (out_data !== 32'h55 || out_last !== 1'b0) begin
         errors++; $display("FAIL bp_beat1: d=%h l=%b want 00000055 0", out_data, out_last);
      end
      step();
      checks++;
      if (out_data !== 32'h66 || out_last !== 1'b1) begin
         errors++; $display("FAIL bp_beat2: d=%h l=%b want 00000066 1", out_data, out_last);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_end: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_saturation();
      in_valid = 4'b0001; in_data = {96'd0, 32'h77};
      step();
      in_valid = 4'b0000;
      checks++;
      if (out_data !== 32'h000000A1) begin
         errors++; $display("FAIL sat_hdr0: d=%h want 000000a1", out_data);
      end
      step();
      step();
      while (cyc < 43) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL sat_quiet: out_valid=%b want 0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h000000F0 || out_last !== 1'b1) begin
         errors++; $display("FAIL sat_empty: v=%b d=%h l=%b want 1 000000f0 1", out_valid, out_data, out_last);
      end
      step();
      step();
      in_valid = 4'b0010; in_data = {64'd0, 32'hBB, 32'd0};
      step();
      in_valid = 4'b0000;
      checks++;
      if (out_data !== 32'h00000032 || out_last !== 1'b0) begin
         errors++; $display("FAIL sat_restart: d=%h l=%b want 00000032 0", out_data, out_last);
      end
      step();
      checks++;
      if (out_data !== 32'hBB || out_last !== 1'b1) begin
         errors++; $display("FAIL sat_beat: d=%h l=%b want 000000bb 1", out_data, out_last);
      end
      step();
   endtask

   task automatic test_reset_mid();
      in_valid = 4'b1111; in_data = {32'h84, 32'h83, 32'h82, 32'h81};
      step();
      in_valid = 4'b0000;
      checks++;
      if (out_data !== 32'h0000003F) begin
         errors++; $display("FAIL rmid_hdr: d=%h want 0000003f", out_data);
      end
      step();
      checks++;
      if (out_data !== 32'h81 || out_last !== 1'b0) begin
         errors++; $display("FAIL rmid_beat: d=%h l=%b want 00000081 0", out_data, out_last);
      end
      rstn = 1'b0; in_valid = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++; $display("FAIL rmid_ready: got %b want 0000", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
         errors++; $display("FAIL rmid_drop: v=%b l=%b want 0 0", out_valid, out_last);
      end
      in_valid = 4'b0000; rstn = 1'b1; cyc = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_quiet%0d: out_valid=%b want 0", i, out_valid);
         end
      end
      in_valid = 4'b0001; in_data = {96'd0, 32'h99};
      step();
      in_valid = 4'b0000;
      checks++;
      if (out_data !== 32'h00000031 || out_last !== 1'b0) begin
         errors++; $display("FAIL rmid_post_hdr: d=%h l=%b want 00000031 0", out_data, out_last);
      end
      step();
      checks++;
      if (out_data !== 32'h99 || out_last !== 1'b1) begin
         errors++; $display("FAIL rmid_post_beat: d=%h l=%b want 00000099 1", out_data, out_last);
      end
      step();
   endtask

   task automatic test_stream();
      logic [3:0]  v, hs, rem, exp_bm, in_hs_bm;
      logic [31:0] d [4];
      logic [31:0] prev_data, exp_word, got;
      logic        prev_ov, prev_stall, prev_last, pkt_active, in_hdr, drain;
      int          cap_cyc, last_cap, in_hs_cyc, exp_delta, ch, qleft;
      longint      sum_exp, sum_obs;
      rstn = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
      step(); step();
      rstn = 1'b1; cyc = 0;
      v = 4'b0000; rem = 4'b0000; in_hs_bm = 4'b0000;
      for (int c = 0; c < 4; c++) d[c] = 32'd0;
      prev_data = 32'd0; prev_ov = 1'b0; prev_stall = 1'b0; prev_last = 1'b0;
      pkt_active = 1'b0; in_hdr = 1'b0;
      last_cap = 0; in_hs_cyc = -10; sum_exp = 0; sum_obs = 0;
      for (int n = 0; n < 10300; n++) begin
         drain = (n >= 10000);
         for (int c = 0; c < 4; c++) begin
            if (!drain && !v[c] && $urandom_range(0, 7) == 0) begin
               v[c] = 1'b1; d[c] = $urandom;
            end
         end
         in_valid = v; in_data = {d[3], d[2], d[1], d[0]};
         out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
         #1;
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
               errors++; $display("FAIL stream_hold cyc %0d: d=%h l=%b want %h %b", cyc, out_data, out_last, prev_data, prev_last);
            end
         end
         if (out_valid === 1'b1 && !prev_ov) begin
            cap_cyc = cyc - 1;
            exp_bm = (in_hs_cyc == cap_cyc) ? in_hs_bm : 4'b0000;
            exp_delta = (cap_cyc - last_cap > 15) ? 15 : cap_cyc - last_cap;
            exp_word = {24'd0, 4'(exp_delta), exp_bm};
            sum_exp += exp_delta;
            sum_obs += out_data[7:4];
            checks++;
            if (out_data !== exp_word || out_last !== (exp_bm == 4'b0000)) begin
               errors++; $display("FAIL stream_hdr cyc %0d: d=%h l=%b want %h %b", cyc, out_data, out_last, exp_word, exp_bm == 4'b0000);
            end
            last_cap = cap_cyc; pkt_active = 1'b1; in_hdr = 1'b1; rem = exp_bm;
         end
         hs = v & in_ready;
         checks++;
         if (in_ready !== v && in_ready !== 4'b0000) begin
            errors++; $display("FAIL stream_ready cyc %0d: got %b want %b or 0000", cyc, in_ready, v);
         end
         for (int c = 0; c < 4; c++) begin
            if (hs[c]) begin
               q[c].push_back(d[c]); v[c] = 1'b0;
            end
         end
         if (hs != 4'b0000) begin
            in_hs_cyc = cyc; in_hs_bm = hs;
         end
         if (out_valid === 1'b1 && out_ready) begin
            if (!pkt_active) begin
               checks++; errors++;
               $display("FAIL stream_extra cyc %0d: beat %h outside any packet", cyc, out_data);
            end else if (in_hdr) begin
               in_hdr = 1'b0;
               if (rem == 4'b0000) pkt_active = 1'b0;
            end else begin
               ch = 0;
               for (int c = 3; c >= 0; c--) if (rem[c]) ch = c;
               rem[ch] = 1'b0;
               checks++;
               if (q[ch].size() == 0) begin
                  errors++; $display("FAIL stream_beat cyc %0d: got %h for ch%0d want no beat", cyc, out_data, ch);
               end else begin
                  got = q[ch].pop_front();
                  if (out_data !== got || out_last !== (rem == 4'b0000)) begin
                     errors++; $display("FAIL stream_beat cyc %0d ch%0d: d=%h l=%b want %h %b", cyc, ch, out_data, out_last, got, rem == 4'b0000);
                  end
               end
               if (rem == 4'b0000) pkt_active = 1'b0;
            end
         end
         prev_ov = (out_valid === 1'b1);
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data = out_data; prev_last = out_last;
         step();
      end
      qleft = 0;
      for (int c = 0; c < 4; c++) qleft += q[c].size();
      checks++;
      if (qleft != 0 || pkt_active) begin
         errors++; $display("FAIL stream_drain: %0d records left, pkt_active=%b want 0 0", qleft, pkt_active);
      end
      checks++;
      if (sum_obs != sum_exp) begin
         errors++; $display("FAIL stream_delta_sum: got %0d want %0d", sum_obs, sum_exp);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      test_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
